// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the parametrised floating-point datapath.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_t;

  localparam int unsigned FP_MAX_W = 128;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
    logic [FP_MAX_W-1:0] v;
    v = ((FP_MAX_W'(1) << (exp_w + 1)) - FP_MAX_W'(1)) << (man_w - 1);
    return v;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational S3: normalise the significand product, round to nearest-even,
// and pack the result together with special-value and exception handling.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned N     = 1 + EXP_W + MAN_W,
  localparam int unsigned XW    = EXP_W + 2,
  localparam int unsigned PW    = 2 * MAN_W + 2
) (
  input  logic [PW-1:0] prod,
  input  logic [XW-1:0] exp_sum,
  input  logic          sign,
  input  fp_class_t     cls,
  output logic [N-1:0]  result,
  output logic          ovf,
  output logic          unf,
  output logic          inv
);

  localparam logic [N-1:0]  QNAN = N'(fp_qnan(EXP_W, MAN_W));
  localparam int unsigned   EMAX = 2 * fp_bias(EXP_W) + 1;

  logic                top;
  logic [2*MAN_W:0]    norm;
  logic [MAN_W-1:0]    frac;
  logic                guard;
  logic                rnd;
  logic                sticky;
  logic                round_up;
  logic [MAN_W:0]      frac_sum;
  logic [MAN_W-1:0]    frac_fin;
  logic [XW-1:0]       exp_fin;

  // Align so the hidden one sits at bit 2*MAN_W, then split fraction/guard/round/sticky.
  always_comb begin
    top      = prod[PW-1];
    norm     = top ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    frac     = norm[2*MAN_W:MAN_W+1];
    guard    = norm[MAN_W];
    rnd      = norm[MAN_W-1];
    sticky   = |norm[MAN_W-2:0];
    round_up = guard & (rnd | sticky | frac[0]);
    frac_sum = {1'b0, frac} + (MAN_W+1)'(round_up);
    frac_fin = frac_sum[MAN_W] ? '0 : frac_sum[MAN_W-1:0];
    exp_fin  = exp_sum + XW'(top) + XW'(frac_sum[MAN_W]);
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unf    = 1'b0;
    inv    = 1'b0;
    unique case (cls)
      CLS_NAN: begin
        result = QNAN;
        inv    = 1'b1;
      end
      CLS_INF:  result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: result = {sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (exp_fin[XW-1] || exp_fin == '0) begin
          result = {sign, {(EXP_W+MAN_W){1'b0}}};
          unf    = 1'b1;
        end else if (exp_fin >= XW'(EMAX)) begin
          result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf    = 1'b1;
        end else begin
          result = {sign, exp_fin[EXP_W-1:0], frac_fin};
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake,
// RNE rounding, DAZ/FTZ and overflow/underflow/invalid flags.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned N     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_inv
);

  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned BIAS = fp_bias(EXP_W);

  // S1 state
  logic            s1_valid;
  logic            s1_sign;
  fp_class_t       s1_cls;
  logic [XW-1:0]   s1_exp;
  logic [SW-1:0]   s1_ma;
  logic [SW-1:0]   s1_mb;

  // S2 state
  logic            s2_valid;
  logic            s2_sign;
  fp_class_t       s2_cls;
  logic [XW-1:0]   s2_exp;
  logic [PW-1:0]   s2_prod;

  logic            load2;
  logic            load3;

  fp_class_t       cls_a;
  fp_class_t       cls_b;
  fp_class_t       cls_res;

  logic [N-1:0]    rn_result;
  logic            rn_ovf;
  logic            rn_unf;
  logic            rn_inv;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == '0)      return CLS_ZERO;
    else if (&e)      return (f != '0) ? CLS_NAN : CLS_INF;
    else              return CLS_NORM;
  endfunction

  // A stage loads when empty or when its content moves on this cycle.
  always_comb begin
    load3    = !out_valid || out_ready;
    load2    = !s2_valid || load3;
    in_ready = !s1_valid || load2;
  end

  // Special-case priority: NaN, inf*zero, inf, zero, then the normal path.
  always_comb begin
    cls_a   = classify(a[N-2 -: EXP_W], a[MAN_W-1:0]);
    cls_b   = classify(b[N-2 -: EXP_W], b[MAN_W-1:0]);
    cls_res = CLS_NORM;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN)
      cls_res = CLS_NAN;
    else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF))
      cls_res = CLS_NAN;
    else if (cls_a == CLS_INF || cls_b == CLS_INF)
      cls_res = CLS_INF;
    else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
      cls_res = CLS_ZERO;
  end

  // S1: unpack, classify, biased exponent sum in XW-bit two's complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_exp   <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= a[N-1] ^ b[N-1];
        s1_cls  <= cls_res;
        s1_exp  <= XW'(a[N-2 -: EXP_W]) + XW'(b[N-2 -: EXP_W]) - XW'(BIAS);
        s1_ma   <= {1'b1, a[MAN_W-1:0]};
        s1_mb   <= {1'b1, b[MAN_W-1:0]};
      end
    end
  end

  // S2: significand multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls   <= CLS_ZERO;
      s2_exp   <= '0;
      s2_prod  <= '0;
    end else if (load2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_cls  <= s1_cls;
        s2_exp  <= s1_exp;
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      end
    end
  end

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .prod    (s2_prod),
    .exp_sum (s2_exp),
    .sign    (s2_sign),
    .cls     (s2_cls),
    .result  (rn_result),
    .ovf     (rn_ovf),
    .unf     (rn_unf),
    .inv     (rn_inv)
  );

  // S3: output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (load3) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result   <= rn_result;
        flag_ovf <= rn_ovf;
        flag_unf <= rn_unf;
        flag_inv <= rn_inv;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe at default (single-precision) parameters:
// arithmetic vectors, special values, back-pressure and mid-stream reset.
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inv;

  int n_cmp;
  int n_bad;

  logic [31:0] bp_a [5];
  logic [31:0] bp_r [5];

  fp_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inv  (flag_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, flag_ovf, flag_unf, flag_inv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: accepted on the first edge, visible after the third.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic [2:0] ef);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, ".lat1"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".lat2"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, result, er);
    check({tag, ".flags"}, flags(), {29'd0, ef});
    step();
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bp_a[0] = 32'h3F800000; bp_r[0] = 32'h40000000;
    bp_a[1] = 32'h40000000; bp_r[1] = 32'h40800000;
    bp_a[2] = 32'h40400000; bp_r[2] = 32'h40C00000;
    bp_a[3] = 32'h40800000; bp_r[3] = 32'h41000000;
    bp_a[4] = 32'h40A00000; bp_r[4] = 32'h41200000;

    // Reset state
    #3;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.flags", flags(), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Arithmetic and special values; flags packed as {ovf, unf, inv}
    run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    run_op("mul_sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run_op("mul_neg",     32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000);
    run_op("tie_up",      32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000);
    run_op("tie_even",    32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000);
    run_op("ovf",         32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
    run_op("unf",         32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
    run_op("neg_zero",    32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    run_op("daz_subnorm", 32'h00000001, 32'h3F800000, 32'h00000000, 3'b000);
    run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    run_op("zero_x_ninf", 32'h80000000, 32'hFF800000, 32'h7FC00000, 3'b001);
    run_op("snan_op",     32'h7FA00000, 32'h3F800000, 32'h7FC00000, 3'b001);
    run_op("neg_nan_op",  32'hFFC00001, 32'h80000000, 32'h7FC00000, 3'b001);
    run_op("ninf_x_fin",  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);

    // Back-pressure: three ops fill the pipe, the fourth must wait
    out_ready = 1'b0;
    in_valid  = 1'b1;
    b         = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      a = bp_a[i];
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd1);
      step();
    end
    a = bp_a[3];
    check("bp.full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp.stall_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp.stall_result%0d", i), result, bp_r[0]);
      check($sformatf("bp.stall_in_ready%0d", i), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_in_ready", 32'(in_ready), 32'd1);
    step();
    a = bp_a[4];
    check("bp.out1", result, bp_r[1]);
    check("bp.in_ready4", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      check($sformatf("bp.valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp.out%0d", i), result, bp_r[i]);
      step();
    end
    check("bp.empty", 32'(out_valid), 32'd0);

    // Reset with three ops in flight
    in_valid = 1'b1;
    b        = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      a = bp_a[i];
      step();
    end
    in_valid = 1'b0;
    check("rm.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm.async_valid", 32'(out_valid), 32'd0);
    check("rm.async_result", result, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rm.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rm.no_stale%0d", i), 32'(out_valid), 32'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
